// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and the decoder control bundle used by the ID/EX stage and the main decoder.
package id_ex_stage_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  // All-zero value is the decoder's op=0000000 encoding and acts as a NOP.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic       alu_src_b;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // MEM result is newer than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(logic [4:0] rs, logic [4:0] rd_m, logic we_m,
                                         logic [4:0] rd_w, logic we_w);
    if (we_m && (rd_m != REG_X0) && (rd_m == rs)) return FWD_MEM;
    if (we_w && (rd_w != REG_X0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard logic: load-use stall, branch/jump flush and EX operand forwarding.
module hazard_unit
  import id_ex_stage_pkg::*;
(
  input  logic [4:0] rs1_d_i,
  input  logic [4:0] rs2_d_i,
  input  logic [4:0] rs1_e_i,
  input  logic [4:0] rs2_e_i,
  input  logic [4:0] rd_e_i,
  input  logic [1:0] result_src_e_i,
  input  logic       pc_src_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic       lw_stall_o,
  output logic       flush_d_o,
  output logic       flush_e_o,
  output logic [1:0] forward_a_e_o,
  output logic [1:0] forward_b_e_o
);

  // A taken branch/jump squashes the dependent instruction anyway, so it suppresses the stall.
  assign lw_stall_o = (result_src_e_i == RES_MEM) && (rd_e_i != REG_X0) &&
                      ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i)) && !pc_src_e_i;

  assign flush_d_o = pc_src_e_i;
  assign flush_e_o = lw_stall_o | pc_src_e_i;

  assign forward_a_e_o = fwd_sel(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
  assign forward_b_e_o = fwd_sel(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register bank with hazard detection and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             JALRD,
  input  logic             ALUSrcAD,
  input  logic             ALUSrcBD,
  input  logic [1:0]       ResultSrcD,
  input  logic [3:0]       ALUControlD,
  input  logic [2:0]       funct3D,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             JumpE,
  output logic             JALRE,
  output logic             ALUSrcAE,
  output logic             ALUSrcBE,
  output logic [1:0]       ResultSrcE,
  output logic [3:0]       ALUControlE,
  output logic [2:0]       funct3E,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] BubbleCount
);

  ctrl_t            ctrl_d, ctrl_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  rd1_q, rd2_q, pc_q, imm_q, pc4_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic             valid_q;
  logic [CNT_W-1:0] bubble_q;
  logic             lw_stall, flush_d, flush_e;

  always_comb begin
    ctrl_d = '{
      reg_write:   RegWriteD,
      result_src:  ResultSrcD,
      mem_write:   MemWriteD,
      branch:      BranchD,
      jump:        JumpD,
      jalr:        JALRD,
      alu_control: ALUControlD,
      alu_src_a:   ALUSrcAD,
      alu_src_b:   ALUSrcBD
    };
  end

  // A bubble is the same all-zero state as reset, so RdE=0 can never match a forward.
  always_ff @(posedge clk) begin
    if (!reset_n || flush_e) begin
      ctrl_q   <= '0;
      funct3_q <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      funct3_q <= funct3D;
      rd1_q    <= RD1D;
      rd2_q    <= RD2D;
      pc_q     <= PCD;
      imm_q    <= ImmExtD;
      pc4_q    <= PCPlus4D;
      rs1_q    <= Rs1D;
      rs2_q    <= Rs2D;
      rd_q     <= RdD;
      valid_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bubble_q <= '0;
    end else if (flush_e && (bubble_q != '1)) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  hazard_unit u_hazard_unit (
    .rs1_d_i       (Rs1D),
    .rs2_d_i       (Rs2D),
    .rs1_e_i       (rs1_q),
    .rs2_e_i       (rs2_q),
    .rd_e_i        (rd_q),
    .result_src_e_i(ctrl_q.result_src),
    .pc_src_e_i    (PCSrcE),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .lw_stall_o    (lw_stall),
    .flush_d_o     (flush_d),
    .flush_e_o     (flush_e),
    .forward_a_e_o (ForwardAE),
    .forward_b_e_o (ForwardBE)
  );

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign BranchE     = ctrl_q.branch;
  assign JumpE       = ctrl_q.jump;
  assign JALRE       = ctrl_q.jalr;
  assign ALUSrcAE    = ctrl_q.alu_src_a;
  assign ALUSrcBE    = ctrl_q.alu_src_b;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_control;
  assign funct3E     = funct3_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign PCE         = pc_q;
  assign ImmExtE     = imm_q;
  assign PCPlus4E    = pc4_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign ValidE      = valid_q;
  assign StallF      = lw_stall;
  assign StallD      = lw_stall;
  assign FlushD      = flush_d;
  assign BubbleCount = bubble_q;

endmodule
